writeback_stage: RTL and testbench

Parametrised writeback stage for the vector pipeline. It selects the per-instruction result from the memory, ALU or auxiliary path and registers it in a one-entry output buffer with a valid/ready handshake toward the register file. It generates per-lane register write enables and keeps retire and stall performance counters with overflow and illegal-select flags. It sits between the memory-access pipeline register and the register-file write port.

---
 rtl/writeback_stage_if.sv | 42 ++++
 rtl/writeback_stage.sv | 123 ++++++++++++
 tb/tb_writeback_stage.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// Writeback stage bus: upstream instruction fields, register-file handshake,
// and counter/flag outputs.
interface writeback_stage_if #(
    parameter int DATA_W = 128,
    parameter int LANES  = 4,
    parameter int CNT_W  = 32,
    parameter int RD_W   = 5
);
    logic              ValidW;
    logic              ReadyW;
    logic [1:0]        ResultSrcW;
    logic [DATA_W-1:0] ALU_ResultW;
    logic [DATA_W-1:0] ReadDataW;
    logic [DATA_W-1:0] AuxDataW;
    logic              RegWriteW;
    logic [RD_W-1:0]   RdW;
    logic [LANES-1:0]  LaneMaskW;
    logic              RfReady;
    logic              CountClr;
    logic              OutValid;
    logic [DATA_W-1:0] ResultW;
    logic [RD_W-1:0]   RdOut;
    logic [LANES-1:0]  LaneWe;
    logic [CNT_W-1:0]  RetireCount;
    logic [CNT_W-1:0]  StallCount;
    logic              CountOvf;
    logic              SrcErr;

    modport master (
        output ValidW, ResultSrcW, ALU_ResultW, ReadDataW, AuxDataW,
        output RegWriteW, RdW, LaneMaskW, RfReady, CountClr,
        input  ReadyW, OutValid, ResultW, RdOut, LaneWe,
        input  RetireCount, StallCount, CountOvf, SrcErr
    );

    modport slave (
        input  ValidW, ResultSrcW, ALU_ResultW, ReadDataW, AuxDataW,
        input  RegWriteW, RdW, LaneMaskW, RfReady, CountClr,
        output ReadyW, OutValid, ResultW, RdOut, LaneWe,
        output RetireCount, StallCount, CountOvf, SrcErr
    );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: result select, one-entry output buffer with valid/ready
// toward the register file, per-lane write enables and perf counters.
module writeback_stage #(
    parameter int DATA_W = 128,
    parameter int LANES  = 4,
    parameter int CNT_W  = 32,
    parameter int RD_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    writeback_stage_if.slave   wb
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [LANES-1:0]  lane_we_q, lane_we_d;
    logic [CNT_W-1:0]  retire_q, retire_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              ovf_q, ovf_d;
    logic              src_err_q, src_err_d;

    logic              ready;
    logic              accept;
    logic              drain;
    logic              stall;
    logic              src_bad;
    logic [DATA_W-1:0] sel_data;
    logic [CNT_W:0]    retire_inc;
    logic [CNT_W:0]    stall_inc;

    assign ready   = !out_valid_q || wb.RfReady;
    assign accept  = wb.ValidW && ready;
    assign drain   = out_valid_q && wb.RfReady;
    assign stall   = out_valid_q && !wb.RfReady;
    assign src_bad = (wb.ResultSrcW == 2'b11);

    assign retire_inc = {1'b0, retire_q} + {{CNT_W{1'b0}}, 1'b1};
    assign stall_inc  = {1'b0, stall_q} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        sel_data = '0;
        case (wb.ResultSrcW)
            2'b00:   sel_data = wb.ReadDataW;
            2'b01:   sel_data = wb.ALU_ResultW;
            2'b10:   sel_data = wb.AuxDataW;
            default: sel_data = '0;
        endcase
    end

    // Buffer holds its payload when not reloading; only OutValid drops on drain.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        rd_d        = rd_q;
        lane_we_d   = lane_we_q;
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = sel_data;
            rd_d        = wb.RdW;
            lane_we_d   = (wb.RegWriteW && !src_bad) ? wb.LaneMaskW : '0;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    // Clear wins over any same-cycle increment or flag set.
    always_comb begin
        retire_d  = retire_q;
        stall_d   = stall_q;
        ovf_d     = ovf_q;
        src_err_d = src_err_q;
        if (wb.CountClr) begin
            retire_d  = '0;
            stall_d   = '0;
            ovf_d     = 1'b0;
            src_err_d = 1'b0;
        end else begin
            if (drain) begin
                retire_d = retire_inc[CNT_W-1:0];
                if (retire_inc[CNT_W]) ovf_d = 1'b1;
            end
            if (stall) begin
                stall_d = stall_inc[CNT_W-1:0];
                if (stall_inc[CNT_W]) ovf_d = 1'b1;
            end
            if (accept && src_bad) src_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            rd_q        <= '0;
            lane_we_q   <= '0;
            retire_q    <= '0;
            stall_q     <= '0;
            ovf_q       <= 1'b0;
            src_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            lane_we_q   <= lane_we_d;
            retire_q    <= retire_d;
            stall_q     <= stall_d;
            ovf_q       <= ovf_d;
            src_err_q   <= src_err_d;
        end
    end

    assign wb.ReadyW      = ready;
    assign wb.OutValid    = out_valid_q;
    assign wb.ResultW     = result_q;
    assign wb.RdOut       = rd_q;
    assign wb.LaneWe      = lane_we_q;
    assign wb.RetireCount = retire_q;
    assign wb.StallCount  = stall_q;
    assign wb.CountOvf    = ovf_q;
    assign wb.SrcErr      = src_err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed plus randomized bench for writeback_stage against a
// cycle-level behavioural model (4-bit counters to exercise wrap).
module tb_writeback_stage;

    localparam int DW  = 128;
    localparam int LN  = 4;
    localparam int CW  = 4;
    localparam int RW  = 5;
    localparam int MOD = 1 << CW;

    logic clk;
    logic rst;

    writeback_stage_if #(.DATA_W(DW), .LANES(LN), .CNT_W(CW), .RD_W(RW)) bus ();

    writeback_stage #(.DATA_W(DW), .LANES(LN), .CNT_W(CW), .RD_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    bit          m_v;
    logic [DW-1:0] m_res;
    logic [RW-1:0] m_rd;
    logic [LN-1:0] m_we;
    int          m_ret;
    int          m_stall;
    bit          m_ovf;
    bit          m_err;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set(input bit v, input logic [1:0] src, input bit rw,
                       input logic [RW-1:0] rd, input logic [LN-1:0] mask,
                       input bit rfr, input bit clr);
        bus.ValidW      = v;
        bus.ResultSrcW  = src;
        bus.RegWriteW   = rw;
        bus.RdW         = rd;
        bus.LaneMaskW   = mask;
        bus.RfReady     = rfr;
        bus.CountClr    = clr;
        bus.ALU_ResultW = rnd128();
        bus.ReadDataW   = rnd128();
        bus.AuxDataW    = rnd128();
    endtask

    task automatic check_state();
        chk("out_valid", bus.OutValid, m_v);
        chk("retire", bus.RetireCount, m_ret);
        chk("stall", bus.StallCount, m_stall);
        chk("ovf", bus.CountOvf, m_ovf);
        chk("src_err", bus.SrcErr, m_err);
        if (m_v) begin
            chk("result", bus.ResultW, m_res);
            chk("rd", bus.RdOut, m_rd);
            chk("lane_we", bus.LaneWe, m_we);
        end
    endtask

    // One clock: check handshake, advance the model, check registered state.
    task automatic tick();
        bit rdy, acc, drn, stl;
        logic [DW-1:0] d;
        #1;
        rdy = !m_v || bus.RfReady;
        chk("ready", bus.ReadyW, rdy);
        acc = bus.ValidW && rdy;
        drn = m_v && bus.RfReady;
        stl = m_v && !bus.RfReady;
        case (bus.ResultSrcW)
            2'd0:    d = bus.ReadDataW;
            2'd1:    d = bus.ALU_ResultW;
            2'd2:    d = bus.AuxDataW;
            default: d = '0;
        endcase
        @(posedge clk);
        #1;
        if (bus.CountClr) begin
            m_ret = 0; m_stall = 0; m_ovf = 0; m_err = 0;
        end else begin
            if (drn) begin
                m_ret = (m_ret + 1) % MOD;
                if (m_ret == 0) m_ovf = 1;
            end
            if (stl) begin
                m_stall = (m_stall + 1) % MOD;
                if (m_stall == 0) m_ovf = 1;
            end
            if (acc && bus.ResultSrcW == 2'd3) m_err = 1;
        end
        if (acc) begin
            m_v   = 1;
            m_res = d;
            m_rd  = bus.RdW;
            m_we  = (bus.RegWriteW && bus.ResultSrcW != 2'd3) ? bus.LaneMaskW : '0;
        end else if (drn) begin
            m_v = 0;
        end
        check_state();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_v = 0; m_res = '0; m_rd = '0; m_we = '0;
        m_ret = 0; m_stall = 0; m_ovf = 0; m_err = 0;
        chk("rst_out_valid", bus.OutValid, 1'b0);
        chk("rst_result", bus.ResultW, '0);
        chk("rst_rd", bus.RdOut, '0);
        chk("rst_lane_we", bus.LaneWe, '0);
        chk("rst_retire", bus.RetireCount, '0);
        chk("rst_stall", bus.StallCount, '0);
        chk("rst_ovf", bus.CountOvf, 1'b0);
        chk("rst_src_err", bus.SrcErr, 1'b0);
        bus.RfReady = 1'b0;
        #1;
        chk("rst_ready", bus.ReadyW, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        set(0, 2'd0, 0, 5'd0, 4'h0, 1, 0);
        @(posedge clk);
        #1;
        do_reset();

        // pass-through
        set(1, 2'd1, 1, 5'd3, 4'hF, 1, 0);
        bus.ALU_ResultW = 128'h0A;
        tick();
        chk("pt_result", bus.ResultW, 128'h0A);
        chk("pt_rd", bus.RdOut, 5'd3);
        chk("pt_we", bus.LaneWe, 4'hF);
        set(0, 2'd0, 0, 5'd0, 4'h0, 1, 0);
        tick();
        chk("pt_retire", bus.RetireCount, 4'd1);

        // back-to-back 00/01/10
        for (int s = 0; s < 3; s++) begin
            set(1, 2'(s), 1, 5'(s + 7), 4'hF, 1, 0);
            tick();
        end
        set(0, 2'd0, 0, 5'd0, 4'h0, 1, 0);
        tick();
        chk("b2b_retire", bus.RetireCount, 4'd4);

        // backpressure
        set(0, 2'd0, 0, 5'd0, 4'h0, 1, 1);
        tick();
        set(1, 2'd2, 1, 5'd9, 4'hA, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            set(1, 2'd1, 1, 5'd11, 4'h3, 0, 0);
            tick();
        end
        chk("bp_stall", bus.StallCount, 4'd4);
        set(1, 2'd0, 1, 5'd12, 4'h6, 1, 0);
        tick();
        chk("bp_reload_valid", bus.OutValid, 1'b1);
        chk("bp_reload_rd", bus.RdOut, 5'd12);

        // masking
        set(1, 2'd1, 1, 5'd1, 4'h5, 1, 0);
        tick();
        chk("mask_0101", bus.LaneWe, 4'h5);
        set(1, 2'd1, 0, 5'd2, 4'hF, 1, 0);
        tick();
        chk("mask_nowrite", bus.LaneWe, 4'h0);
        set(0, 2'd0, 0, 5'd0, 4'h0, 1, 0);
        tick();

        // illegal select, then clear during a drain
        set(1, 2'd3, 1, 5'd4, 4'hF, 0, 0);
        tick();
        chk("ill_result", bus.ResultW, '0);
        chk("ill_we", bus.LaneWe, 4'h0);
        chk("ill_err", bus.SrcErr, 1'b1);
        set(0, 2'd0, 0, 5'd0, 4'h0, 0, 0);
        tick();
        chk("ill_err_sticky", bus.SrcErr, 1'b1);
        set(0, 2'd0, 0, 5'd0, 4'h0, 1, 1);
        tick();
        chk("clr_drain_retire", bus.RetireCount, 4'd0);
        chk("clr_err", bus.SrcErr, 1'b0);

        // wrap: 16 drains
        for (int i = 0; i < 16; i++) begin
            set(1, 2'd1, 1, 5'(i), 4'hF, 1, 0);
            tick();
        end
        set(0, 2'd0, 0, 5'd0, 4'h0, 1, 0);
        tick();
        chk("wrap_retire", bus.RetireCount, 4'd0);
        chk("wrap_ovf", bus.CountOvf, 1'b1);

        // reset mid-operation
        set(1, 2'd1, 1, 5'd5, 4'hF, 0, 0);
        tick();
        set(1, 2'd1, 1, 5'd6, 4'hF, 1, 0);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            set($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1, 5'($urandom), 4'($urandom),
                $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
